// File: rtl/sprite_plotter_multi.sv
// Multi-channel car sprite plotter: NUM_SPRITES double-buffered channels share one synchronous sprite ROM.
// Optional macro SPRITE_COLLISION_EN builds a per-frame bounding-box collision detector.

module sprite_plotter_multi #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 47,
  parameter int SPR_H       = 65,
  parameter int CAR_W       = 3,
  parameter int IDX_W       = 5,
  parameter int ADDR_W      = 15,
  parameter int TRANSP_IDX  = 2,
  parameter int ROM_LAT     = 2,
  localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              vs,
  input  logic              reg_we,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [9:0]        reg_x,
  input  logic [9:0]        reg_y,
  input  logic [CAR_W-1:0]  reg_car,
  input  logic              reg_flip,
  input  logic              reg_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              isSprite,
  output logic [IDX_W-1:0]  pix_idx,
  output logic [SEL_W-1:0]  pix_id,
  output logic              collision
);

  logic [9:0]             shX   [NUM_SPRITES];
  logic [9:0]             shY   [NUM_SPRITES];
  logic [CAR_W-1:0]       shCar [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shFlip;
  logic [NUM_SPRITES-1:0] shEn;

  logic [9:0]             actX   [NUM_SPRITES];
  logic [9:0]             actY   [NUM_SPRITES];
  logic [CAR_W-1:0]       actCar [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] actFlip;
  logic [NUM_SPRITES-1:0] actEn;

  logic                   vsQ;
  logic                   commit;
  logic [NUM_SPRITES-1:0] hitVec;
  logic                   anyHit;
  logic [SEL_W-1:0]       winId;
  logic [9:0]             dx;
  logic [9:0]             txEff;
  logic [9:0]             ty;
  logic [ADDR_W-1:0]      addrNext;

  logic                   hit1;
  logic [SEL_W-1:0]       id1;
  logic [ROM_LAT-1:0]     hitPipe;
  logic [SEL_W-1:0]       idPipe [ROM_LAT];
  logic                   opaque;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shX[i]   <= '0;
        shY[i]   <= '0;
        shCar[i] <= '0;
      end
      shFlip <= '0;
      shEn   <= '0;
    end else if (reg_we && (32'(reg_sel) < 32'(NUM_SPRITES))) begin
      shX[reg_sel]    <= reg_x;
      shY[reg_sel]    <= reg_y;
      shCar[reg_sel]  <= reg_car;
      shFlip[reg_sel] <= reg_flip;
      shEn[reg_sel]   <= reg_en;
    end
  end

  // Active copies only move on the frame boundary so a sprite never tears mid-frame.
  assign commit = vs & ~vsQ;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      vsQ <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        actX[i]   <= '0;
        actY[i]   <= '0;
        actCar[i] <= '0;
      end
      actFlip <= '0;
      actEn   <= '0;
    end else begin
      vsQ <= vs;
      if (commit) begin
        actX    <= shX;
        actY    <= shY;
        actCar  <= shCar;
        actFlip <= shFlip;
        actEn   <= shEn;
      end
    end
  end

  // Box ends are formed at 11 bits so a sprite near the right/bottom edge clips instead of wrapping.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : gHit
    logic [10:0] xEnd;
    logic [10:0] yEnd;
    assign xEnd = {1'b0, actX[i]} + 11'(SPR_W);
    assign yEnd = {1'b0, actY[i]} + 11'(SPR_H);
    assign hitVec[i] = actEn[i] &&
                       (DrawX >= actX[i]) && ({1'b0, DrawX} < xEnd) &&
                       (DrawY >= actY[i]) && ({1'b0, DrawY} < yEnd);
  end

  assign anyHit = |hitVec;

  always_comb begin
    winId = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hitVec[i]) winId = SEL_W'(i);
    end
  end

  assign dx       = DrawX - actX[winId];
  assign txEff    = actFlip[winId] ? (10'(SPR_W - 1) - dx) : dx;
  assign ty       = DrawY - actY[winId];
  assign addrNext = ADDR_W'(32'(actCar[winId]) * 32'(SPR_W * SPR_H)
                          + 32'(ty) * 32'(SPR_W) + 32'(txEff));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      hit1     <= 1'b0;
      id1      <= '0;
    end else begin
      hit1 <= anyHit;
      id1  <= winId;
      if (anyHit) rom_addr <= addrNext;
    end
  end

  // Hit and id ride alongside the ROM read so they meet rom_data on the same cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      hitPipe <= '0;
      for (int k = 0; k < ROM_LAT; k++) idPipe[k] <= '0;
    end else begin
      hitPipe[0] <= hit1;
      idPipe[0]  <= id1;
      for (int k = 1; k < ROM_LAT; k++) begin
        hitPipe[k] <= hitPipe[k-1];
        idPipe[k]  <= idPipe[k-1];
      end
    end
  end

  assign opaque = hitPipe[ROM_LAT-1] && (rom_data != IDX_W'(TRANSP_IDX));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      isSprite <= 1'b0;
      pix_idx  <= '0;
      pix_id   <= '0;
    end else begin
      isSprite <= opaque;
      pix_idx  <= opaque ? rom_data : '0;
      pix_id   <= hitPipe[ROM_LAT-1] ? idPipe[ROM_LAT-1] : '0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  localparam logic [NUM_SPRITES-1:0] LSB_ONE = 1;

  logic multiHit;
  logic collFlag;

  // Clearing the lowest set bit leaves something only when two or more channels overlap here.
  assign multiHit = |(hitVec & (hitVec - LSB_ONE));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      collFlag  <= 1'b0;
      collision <= 1'b0;
    end else if (commit) begin
      collision <= collFlag;
      collFlag  <= 1'b0;
    end else if (multiHit) begin
      collFlag <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_plotter_multi.sv
// Directed bench for sprite_plotter_multi with a behavioural ROM of ROM_LAT cycles latency.
// Collision expectations follow SPRITE_COLLISION_EN when the bench is built with it.

module tb_sprite_plotter_multi;

  localparam int ROM_LAT = 2;
`ifdef SPRITE_COLLISION_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        vs;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic [9:0]  reg_x;
  logic [9:0]  reg_y;
  logic [2:0]  reg_car;
  logic        reg_flip;
  logic        reg_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [14:0] rom_addr;
  logic [4:0]  rom_data;
  logic        isSprite;
  logic [4:0]  pix_idx;
  logic [1:0]  pix_id;
  logic        collision;

  int errors = 0;
  int checks = 0;

  logic [14:0] forceAddr;
  logic [4:0]  forceVal;
  logic [4:0]  defaultVal;
  logic [4:0]  romPipe [ROM_LAT];

  logic [14:0] obsAddr;
  logic        obsSprite;
  logic [4:0]  obsIdx;
  logic [1:0]  obsId;

  sprite_plotter_multi #(.ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .Reset(Reset), .vs(vs),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_x(reg_x), .reg_y(reg_y),
    .reg_car(reg_car), .reg_flip(reg_flip), .reg_en(reg_en),
    .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .isSprite(isSprite), .pix_idx(pix_idx), .pix_id(pix_id), .collision(collision)
  );

  always #5 clk = ~clk;

  // ROM returns forceVal at one chosen address and defaultVal everywhere else.
  always @(posedge clk) begin
    romPipe[0] <= (rom_addr == forceAddr) ? forceVal : defaultVal;
    for (int k = 1; k < ROM_LAT; k++) romPipe[k] <= romPipe[k-1];
  end
  assign rom_data = romPipe[ROM_LAT-1];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] car, input logic flip, input logic en);
    reg_we = 1'b1; reg_sel = sel; reg_x = x; reg_y = y; reg_car = car; reg_flip = flip; reg_en = en;
    tick(1);
    reg_we = 1'b0;
  endtask

  task automatic pulseVs();
    vs = 1'b1;
    tick(1);
    vs = 1'b0;
    tick(1);
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    DrawX = x; DrawY = y;
    tick(1);
    obsAddr = rom_addr;
    tick(ROM_LAT + 1);
    obsSprite = isSprite; obsIdx = pix_idx; obsId = pix_id;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (rom_addr !== 15'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", rom_addr); end
    checks++; if (isSprite !== 1'b0) begin errors++; $display("[TB] FAIL reset_isSprite: got %0b want 0", isSprite); end
    checks++; if (pix_idx !== 5'd0) begin errors++; $display("[TB] FAIL reset_pix_idx: got %0d want 0", pix_idx); end
    checks++; if (pix_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_pix_id: got %0d want 0", pix_id); end
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL reset_collision: got %0b want 0", collision); end
    Reset = 1'b0;
    tick(1);
    applyStimulus(10'd0, 10'd0);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL reset_disabled: got %0b want 0", obsSprite); end
  endtask

  task automatic test_basic();
    writeReg(2'd0, 10'd100, 10'd200, 3'd7, 1'b0, 1'b1);
    pulseVs();
    forceAddr = 15'd21385; forceVal = 5'd5;
    applyStimulus(10'd100, 10'd200);
    checks++; if (obsAddr !== 15'd21385) begin errors++; $display("[TB] FAIL basic_addr: got %0d want 21385", obsAddr); end
    checks++; if (obsSprite !== 1'b1) begin errors++; $display("[TB] FAIL basic_isSprite: got %0b want 1", obsSprite); end
    checks++; if (obsIdx !== 5'd5) begin errors++; $display("[TB] FAIL basic_pix_idx: got %0d want 5", obsIdx); end
    checks++; if (obsId !== 2'd0) begin errors++; $display("[TB] FAIL basic_pix_id: got %0d want 0", obsId); end
    applyStimulus(10'd110, 10'd203);
    checks++; if (obsAddr !== 15'd21536) begin errors++; $display("[TB] FAIL basic_addr2: got %0d want 21536", obsAddr); end
    checks++; if (obsIdx !== 5'd11) begin errors++; $display("[TB] FAIL basic_pix_idx2: got %0d want 11", obsIdx); end
  endtask

  task automatic test_flip();
    writeReg(2'd0, 10'd100, 10'd200, 3'd7, 1'b1, 1'b1);
    pulseVs();
    applyStimulus(10'd100, 10'd200);
    checks++; if (obsAddr !== 15'd21431) begin errors++; $display("[TB] FAIL flip_left_addr: got %0d want 21431", obsAddr); end
    applyStimulus(10'd146, 10'd200);
    checks++; if (obsAddr !== 15'd21385) begin errors++; $display("[TB] FAIL flip_right_addr: got %0d want 21385", obsAddr); end
    checks++; if (obsIdx !== 5'd5) begin errors++; $display("[TB] FAIL flip_right_idx: got %0d want 5", obsIdx); end
    applyStimulus(10'd147, 10'd200);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL flip_x147: got %0b want 0", obsSprite); end
    checks++; if (obsAddr !== 15'd21385) begin errors++; $display("[TB] FAIL flip_addr_hold: got %0d want 21385", obsAddr); end
    applyStimulus(10'd99, 10'd200);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL flip_x99: got %0b want 0", obsSprite); end
    applyStimulus(10'd146, 10'd264);
    checks++; if (obsAddr !== 15'd24393) begin errors++; $display("[TB] FAIL flip_bottom_addr: got %0d want 24393", obsAddr); end
    checks++; if (obsSprite !== 1'b1) begin errors++; $display("[TB] FAIL flip_bottom_hit: got %0b want 1", obsSprite); end
    applyStimulus(10'd146, 10'd265);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL flip_y265: got %0b want 0", obsSprite); end
  endtask

  task automatic test_priority();
    writeReg(2'd0, 10'd50, 10'd50, 3'd1, 1'b0, 1'b1);
    writeReg(2'd1, 10'd50, 10'd50, 3'd2, 1'b0, 1'b1);
    pulseVs();
    forceAddr = 15'd3055; forceVal = 5'd2;
    applyStimulus(10'd50, 10'd50);
    checks++; if (obsAddr !== 15'd3055) begin errors++; $display("[TB] FAIL prio_addr: got %0d want 3055", obsAddr); end
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL prio_transp_isSprite: got %0b want 0", obsSprite); end
    checks++; if (obsIdx !== 5'd0) begin errors++; $display("[TB] FAIL prio_transp_idx: got %0d want 0", obsIdx); end
    forceVal = 5'd9;
    applyStimulus(10'd50, 10'd50);
    checks++; if (obsIdx !== 5'd9) begin errors++; $display("[TB] FAIL prio_idx: got %0d want 9", obsIdx); end
    checks++; if (obsId !== 2'd0) begin errors++; $display("[TB] FAIL prio_id: got %0d want 0", obsId); end
    writeReg(2'd0, 10'd50, 10'd50, 3'd1, 1'b0, 1'b0);
    pulseVs();
    applyStimulus(10'd50, 10'd50);
    checks++; if (obsAddr !== 15'd6110) begin errors++; $display("[TB] FAIL prio_ch1_addr: got %0d want 6110", obsAddr); end
    checks++; if (obsId !== 2'd1) begin errors++; $display("[TB] FAIL prio_ch1_id: got %0d want 1", obsId); end
    checks++; if (obsIdx !== 5'd11) begin errors++; $display("[TB] FAIL prio_ch1_idx: got %0d want 11", obsIdx); end
  endtask

  task automatic test_commit();
    forceAddr = 15'h7FFF;
    writeReg(2'd2, 10'd300, 10'd10, 3'd0, 1'b0, 1'b1);
    applyStimulus(10'd300, 10'd10);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL commit_shadow_only: got %0b want 0", obsSprite); end
    pulseVs();
    applyStimulus(10'd300, 10'd10);
    checks++; if (obsSprite !== 1'b1) begin errors++; $display("[TB] FAIL commit_hit: got %0b want 1", obsSprite); end
    checks++; if (obsId !== 2'd2) begin errors++; $display("[TB] FAIL commit_id: got %0d want 2", obsId); end
    checks++; if (obsAddr !== 15'd0) begin errors++; $display("[TB] FAIL commit_addr: got %0d want 0", obsAddr); end
    reg_we = 1'b1; reg_sel = 2'd2; reg_x = 10'd400; reg_y = 10'd10; reg_car = 3'd0; reg_flip = 1'b0; reg_en = 1'b1;
    vs = 1'b1;
    tick(1);
    reg_we = 1'b0; vs = 1'b0;
    tick(1);
    applyStimulus(10'd400, 10'd10);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL commit_same_cycle_new: got %0b want 0", obsSprite); end
    applyStimulus(10'd300, 10'd10);
    checks++; if (obsSprite !== 1'b1) begin errors++; $display("[TB] FAIL commit_same_cycle_old: got %0b want 1", obsSprite); end
    pulseVs();
    applyStimulus(10'd400, 10'd10);
    checks++; if (obsSprite !== 1'b1) begin errors++; $display("[TB] FAIL commit_second_edge: got %0b want 1", obsSprite); end
  endtask

  task automatic test_clip();
    writeReg(2'd3, 10'd1000, 10'd0, 3'd0, 1'b0, 1'b1);
    pulseVs();
    applyStimulus(10'd5, 10'd0);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL clip_nowrap: got %0b want 0", obsSprite); end
    applyStimulus(10'd1010, 10'd0);
    checks++; if (obsAddr !== 15'd10) begin errors++; $display("[TB] FAIL clip_addr: got %0d want 10", obsAddr); end
    checks++; if (obsId !== 2'd3) begin errors++; $display("[TB] FAIL clip_id: got %0d want 3", obsId); end
    applyStimulus(10'd1023, 10'd64);
    checks++; if (obsAddr !== 15'd3031) begin errors++; $display("[TB] FAIL clip_corner_addr: got %0d want 3031", obsAddr); end
    checks++; if (obsSprite !== 1'b1) begin errors++; $display("[TB] FAIL clip_corner_hit: got %0b want 1", obsSprite); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(10'd1010, 10'd0);
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (isSprite !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_isSprite: got %0b want 0", isSprite); end
    checks++; if (pix_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_pix_id: got %0d want 0", pix_id); end
    checks++; if (pix_idx !== 5'd0) begin errors++; $display("[TB] FAIL rst_mid_pix_idx: got %0d want 0", pix_idx); end
    checks++; if (rom_addr !== 15'd0) begin errors++; $display("[TB] FAIL rst_mid_addr: got %0d want 0", rom_addr); end
    tick(1);
    Reset = 1'b0;
    tick(1);
    pulseVs();
    applyStimulus(10'd1010, 10'd0);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ch3_cleared: got %0b want 0", obsSprite); end
    applyStimulus(10'd300, 10'd10);
    checks++; if (obsSprite !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ch2_cleared: got %0b want 0", obsSprite); end
  endtask

  task automatic test_back_to_back();
    writeReg(2'd3, 10'd1000, 10'd0, 3'd0, 1'b0, 1'b1);
    pulseVs();
    forceAddr = 15'd6; forceVal = 5'd2;
    DrawX = 10'd1005; DrawY = 10'd0;
    tick(1);
    checks++; if (rom_addr !== 15'd5) begin errors++; $display("[TB] FAIL b2b_addr0: got %0d want 5", rom_addr); end
    DrawX = 10'd1006;
    tick(1);
    checks++; if (rom_addr !== 15'd6) begin errors++; $display("[TB] FAIL b2b_addr1: got %0d want 6", rom_addr); end
    DrawX = 10'd1007;
    tick(1);
    checks++; if (rom_addr !== 15'd7) begin errors++; $display("[TB] FAIL b2b_addr2: got %0d want 7", rom_addr); end
    tick(1);
    checks++; if (pix_idx !== 5'd11) begin errors++; $display("[TB] FAIL b2b_out0_idx: got %0d want 11", pix_idx); end
    tick(1);
    checks++; if (isSprite !== 1'b0) begin errors++; $display("[TB] FAIL b2b_out1_transp: got %0b want 0", isSprite); end
    checks++; if (pix_id !== 2'd3) begin errors++; $display("[TB] FAIL b2b_out1_id: got %0d want 3", pix_id); end
    tick(1);
    checks++; if (isSprite !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out2_isSprite: got %0b want 1", isSprite); end
  endtask

  task automatic test_collision();
    DrawX = 10'd0; DrawY = 10'd0;
    writeReg(2'd0, 10'd50, 10'd50, 3'd1, 1'b0, 1'b1);
    writeReg(2'd1, 10'd50, 10'd50, 3'd2, 1'b0, 1'b1);
    pulseVs();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_before: got %0b want 0", collision); end
    applyStimulus(10'd50, 10'd50);
    DrawX = 10'd0; DrawY = 10'd0;
    pulseVs();
    checks++; if (collision !== COLL) begin errors++; $display("[TB] FAIL coll_set: got %0b want %0b", collision, COLL); end
    tick(3);
    checks++; if (collision !== COLL) begin errors++; $display("[TB] FAIL coll_stable: got %0b want %0b", collision, COLL); end
    writeReg(2'd1, 10'd600, 10'd300, 3'd2, 1'b0, 1'b1);
    pulseVs();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_clear: got %0b want 0", collision); end
  endtask

  initial begin
    Reset = 1'b1; vs = 1'b0; reg_we = 1'b0; reg_sel = '0; reg_x = '0; reg_y = '0;
    reg_car = '0; reg_flip = 1'b0; reg_en = 1'b0; DrawX = '0; DrawY = '0;
    forceAddr = 15'h7FFF; forceVal = 5'd0; defaultVal = 5'd11;
    test_reset();
    test_basic();
    test_flip();
    test_priority();
    test_commit();
    test_clip();
    test_reset_mid();
    test_back_to_back();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
